// File: rtl/qpsk_hard_demap_pack.sv
// Hard-decision QPSK demapper: sign bits of I/Q become a 2-bit code,
// packed MSB-first into OUT_WIDTH-bit words behind a one-deep output register.
module qpsk_hard_demap_pack #(
  parameter int WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  localparam int SYMS = OUT_WIDTH / 2,
  localparam int CW = $clog2(SYMS),
  localparam int NW = $clog2(SYMS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 invert_q,
  input  logic [WIDTH-1:0]     i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic [NW-1:0]        o_nsym,
  output logic                 o_tvalid,
  input  logic                 o_tready
);

  logic [OUT_WIDTH-1:0] acc;
  logic [CW-1:0]        sym_cnt;
  logic [1:0]           code;
  logic [OUT_WIDTH-1:0] placed;
  logic                 xfer;
  logic                 last_sym;
  logic                 closing;
  logic                 out_hs;
  logic                 unused_bits;

  // Only the sign bit of each half carries decision information.
  assign unused_bits = ^{i_tdata};

  assign i_tready = ~o_tvalid | o_tready;
  assign xfer     = i_tvalid & i_tready;
  assign out_hs   = o_tvalid & o_tready;
  assign last_sym = (sym_cnt == CW'(SYMS - 1));
  assign closing  = xfer & (last_sym | i_tlast);

  // Zero is treated as positive, so only the MSB matters.
  assign code = {i_tdata[WIDTH-1], i_tdata[WIDTH/2-1] ^ invert_q};

  // Symbol k lands at bits [OUT_WIDTH-1-2k -: 2].
  assign placed = {code, {(OUT_WIDTH-2){1'b0}}} >> {sym_cnt, 1'b0};

  // Accumulate codes of the word under construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      sym_cnt <= '0;
    end else if (xfer) begin
      if (closing) begin
        acc     <= '0;
        sym_cnt <= '0;
      end else begin
        acc     <= acc | placed;
        sym_cnt <= sym_cnt + CW'(1);
      end
    end
  end

  // Single-stage output register; reloads on a closing transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_nsym   <= '0;
      o_tvalid <= 1'b0;
    end else if (clear) begin
      o_tvalid <= 1'b0;
    end else if (closing) begin
      o_tdata  <= acc | placed;
      o_tlast  <= i_tlast;
      o_nsym   <= NW'({1'b0, sym_cnt}) + NW'(1);
      o_tvalid <= 1'b1;
    end else if (out_hs) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpsk_hard_demap_pack.sv
// Bench for qpsk_hard_demap_pack: decision table, packing sequences,
// back-pressure, clear and async reset, checked through a queue.
module tb_qpsk_hard_demap_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        invert_q = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic [4:0]  o_nsym;
  logic        o_tvalid;
  logic        o_tready = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [4:0]  nsym;
  } exp_t;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        inv;
    logic [31:0] exp;
  } vec_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0] POS = 16'h0064;
  localparam logic [15:0] NEG = 16'hFF9C;

  qpsk_hard_demap_pack dut (
    .clk(clk), .reset(reset), .clear(clear), .invert_q(invert_q),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_nsym(o_nsym), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] d, logic l, logic [4:0] n);
    exp_t e;
    e.data = d;
    e.last = l;
    e.nsym = n;
    q_exp.push_back(e);
  endtask

  // Output handshake happens at the next posedge; sample at negedge.
  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", o_tdata);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("word_data", 64'(o_tdata), 64'(e.data));
        chk("word_last", 64'(o_tlast), 64'(e.last));
        chk("word_nsym", 64'(o_nsym), 64'(e.nsym));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(logic [15:0] iv, logic [15:0] qv, logic last, logic inv);
    int n;
    logic rdy;
    n = 0;
    i_tdata = {iv, qv};
    i_tlast = last;
    invert_q = inv;
    i_tvalid = 1'b1;
    do begin
      @(negedge clk);
      rdy = i_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got i_tready=0 expected 1");
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_exp.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(q_exp.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{16'h0064, 16'hFF9C, 1'b0, 32'h40000000};
    tbl[1] = '{16'hFF9C, 16'hFF9C, 1'b0, 32'hC0000000};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 32'h00000000};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 32'h40000000};
    tbl[4] = '{16'h8000, 16'h7FFF, 1'b0, 32'h80000000};
    tbl[5] = '{16'h7FFF, 16'h8000, 1'b1, 32'h00000000};
    tbl[6] = '{16'hFFFF, 16'h0001, 1'b1, 32'hC0000000};

    #12;
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tdata", 64'(o_tdata), 64'd0);
    chk("rst_nsym", 64'(o_nsym), 64'd0);
    chk("rst_tlast", 64'(o_tlast), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_tready", 64'(i_tready), 64'd1);

    // Single-symbol decision table (test 4 included as row 3).
    for (int k = 0; k < 7; k++) begin
      push(tbl[k].exp, 1'b1, 5'd1);
      send(tbl[k].i, tbl[k].q, 1'b1, tbl[k].inv);
    end
    drain();

    // Test 1: full word with tlast on 16th.
    push(32'h55555555, 1'b1, 5'd16);
    for (int k = 0; k < 16; k++) send(POS, NEG, k == 15, 1'b0);
    drain();

    // Test 2: partial word, latency check.
    push(32'hC8000000, 1'b1, 5'd3);
    send(NEG, NEG, 1'b0, 1'b0);
    send(POS, POS, 1'b0, 1'b0);
    chk("lat_before", 64'(o_tvalid), 64'd0);
    send(NEG, POS, 1'b1, 1'b0);
    chk("lat_after", 64'(o_tvalid), 64'd1);
    drain();

    // invert_q changed mid-word only affects later symbols.
    push(32'h10000000, 1'b1, 5'd2);
    send(POS, POS, 1'b0, 1'b0);
    send(POS, POS, 1'b1, 1'b1);
    drain();
    invert_q = 1'b0;

    // Test 3: back-pressure across two full words.
    push(32'hFFFFFFFF, 1'b0, 5'd16);
    push(32'hFFFFFFFF, 1'b0, 5'd16);
    o_tready = 1'b0;
    fork
      for (int k = 0; k < 32; k++) send(NEG, NEG, 1'b0, 1'b0);
      begin
        repeat (30) @(negedge clk);
        chk("bp_tready", 64'(i_tready), 64'd0);
        chk("bp_tvalid", 64'(o_tvalid), 64'd1);
        chk("bp_tdata", 64'(o_tdata), 64'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1 o_tready = 1'b1;
      end
    join
    drain();

    // Test 5: clear drops partial word; clear beats a closing transfer.
    for (int k = 0; k < 5; k++) send(NEG, NEG, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    send(NEG, NEG, 1'b0, 1'b0);
    clear = 1'b1;
    send(NEG, NEG, 1'b1, 1'b0);
    clear = 1'b0;
    chk("clr_tvalid", 64'(o_tvalid), 64'd0);
    push(32'h80000000, 1'b1, 5'd1);
    send(NEG, POS, 1'b1, 1'b0);
    drain();

    // Test 6: async reset with a word pending, then with a partial word.
    o_tready = 1'b0;
    send(NEG, NEG, 1'b1, 1'b0);
    chk("pend_tvalid", 64'(o_tvalid), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_tvalid", 64'(o_tvalid), 64'd0);
    chk("arst_tdata", 64'(o_tdata), 64'd0);
    chk("arst_tlast", 64'(o_tlast), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    o_tready = 1'b1;
    send(NEG, NEG, 1'b0, 1'b0);
    send(NEG, NEG, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    push(32'h40000000, 1'b1, 5'd1);
    send(POS, NEG, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
